// File: rtl/password_entry_buffer.sv
// password_entry_buffer
//   Keypad password-entry buffer for the door-lock datapath. Collects up to
//   N_DIGITS digits (newest digit in the LSBs), supports backspace, clear and
//   submit, rejects out-of-range digits, and latches a complete entry into a
//   held code output on submit.
//
//   Optional feature: define PASSWORD_ENTRY_TIMEOUT_EN to compile in the
//   inactivity timeout that discards a stale partial entry after
//   TIMEOUT_CYCLES idle clocks. Without it o_timeout is tied low.
//
//   Per-cycle priority: clear > submit > backspace > confirm > timeout.
//   All outputs are registered (one-cycle latency from strobe to result).
module password_entry_buffer #(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_DIGIT      = 9,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int CNT_W         = $clog2(N_DIGITS + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [DIGIT_W-1:0]           i_digit,
  input  logic                         i_confirm,
  input  logic                         i_backspace,
  input  logic                         i_clear,
  input  logic                         i_submit,
  output logic [N_DIGITS*DIGIT_W-1:0]  o_entry,
  output logic [CNT_W-1:0]             o_count,
  output logic [N_DIGITS*DIGIT_W-1:0]  o_code,
  output logic                         o_valid,
  output logic                         o_error,
  output logic                         o_timeout
);

  localparam int ENTRY_W = N_DIGITS * DIGIT_W;

  // Buffer state is derived from the digit count; the enum only names it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Parameter sanity: a one-digit password or a sub-2-cycle timeout makes
  // no sense for this buffer.
  if (N_DIGITS < 2) begin : g_chk_digits
    $error("password_entry_buffer: N_DIGITS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("password_entry_buffer: TIMEOUT_CYCLES must be at least 2");
  end

  logic [ENTRY_W-1:0] entry_reg, entry_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [ENTRY_W-1:0] code_reg,  code_next;
  logic               valid_reg, valid_next;
  logic               error_reg, error_next;
  logic               timeout_reg, timeout_next;

  state_t             state;
  logic               any_input;
  logic               digit_ok;
  logic [31:0]        digit_wide;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] pop_entry;

  assign any_input  = i_clear | i_submit | i_backspace | i_confirm;
  // Widen before comparing so MAX_DIGIT >= 2**DIGIT_W simply accepts all.
  assign digit_wide = 32'(i_digit);
  assign digit_ok   = (digit_wide <= 32'(MAX_DIGIT));

  // Per-lane shift networks: push moves every digit up one lane and inserts
  // the new digit at lane 0 (oldest digit falls off the top); pop moves every
  // digit down one lane and zero-fills the top lane.
  genvar gi;
  for (gi = 0; gi < N_DIGITS; gi++) begin : g_lane
    if (gi == 0) begin : g_push_low
      assign push_entry[DIGIT_W-1:0] = i_digit;
    end else begin : g_push_up
      assign push_entry[gi*DIGIT_W +: DIGIT_W] = entry_reg[(gi-1)*DIGIT_W +: DIGIT_W];
    end
    if (gi == N_DIGITS - 1) begin : g_pop_top
      assign pop_entry[gi*DIGIT_W +: DIGIT_W] = '0;
    end else begin : g_pop_down
      assign pop_entry[gi*DIGIT_W +: DIGIT_W] = entry_reg[(gi+1)*DIGIT_W +: DIGIT_W];
    end
  end

  // Decode the buffer state from the held digit count.
  always_comb begin
    state = ST_ENTRY;
    if (count_reg == '0) begin
      state = ST_IDLE;
    end else if (count_reg == CNT_W'(N_DIGITS)) begin
      state = ST_FULL;
    end
  end

`ifdef PASSWORD_ENTRY_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            to_hit;

  // Expires only on a fully idle cycle; any strobe on the same edge wins.
  assign to_hit = (state != ST_IDLE) && !any_input &&
                  (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: runs while digits are held, restarts on any input,
  // on an empty buffer and after it fires.
  always_comb begin
    to_cnt_next = to_cnt_reg + TO_W'(1);
    if (any_input || (state == ST_IDLE) || to_hit) begin
      to_cnt_next = '0;
    end
  end

  // Inactivity counter register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end
`endif

  // Next-state / output decode: only the highest-priority strobe acts.
  always_comb begin
    entry_next   = entry_reg;
    count_next   = count_reg;
    code_next    = code_reg;
    valid_next   = 1'b0;
    error_next   = 1'b0;
    timeout_next = 1'b0;

    if (i_clear) begin
      // Clearing an already empty buffer is not an error.
      entry_next = '0;
      count_next = '0;
    end else if (i_submit) begin
      if (state == ST_FULL) begin
        code_next  = entry_reg;
        valid_next = 1'b1;
      end else begin
        error_next = 1'b1;
      end
      // A partial submit is rejected but still discards the entry.
      entry_next = '0;
      count_next = '0;
    end else if (i_backspace) begin
      if (state == ST_IDLE) begin
        error_next = 1'b1;
      end else begin
        entry_next = pop_entry;
        count_next = count_reg - CNT_W'(1);
      end
    end else if (i_confirm) begin
      // A full buffer never wraps: extra digits are refused.
      if (!digit_ok || (state == ST_FULL)) begin
        error_next = 1'b1;
      end else begin
        entry_next = push_entry;
        count_next = count_reg + CNT_W'(1);
      end
    end
`ifdef PASSWORD_ENTRY_TIMEOUT_EN
    else if (to_hit) begin
      entry_next   = '0;
      count_next   = '0;
      timeout_next = 1'b1;
    end
`endif
  end

  // Buffer, held code and status pulse registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      entry_reg   <= '0;
      count_reg   <= '0;
      code_reg    <= '0;
      valid_reg   <= 1'b0;
      error_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      entry_reg   <= entry_next;
      count_reg   <= count_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      error_reg   <= error_next;
      timeout_reg <= timeout_next;
    end
  end

  assign o_entry   = entry_reg;
  assign o_count   = count_reg;
  assign o_code    = code_reg;
  assign o_valid   = valid_reg;
  assign o_error   = error_reg;
`ifdef PASSWORD_ENTRY_TIMEOUT_EN
  assign o_timeout = timeout_reg;
`else
  // Timeout not compiled in: the pulse register never sets.
  assign o_timeout = timeout_reg & 1'b0;
`endif

endmodule

// File: tb/tb_password_entry_buffer.sv
// tb_password_entry_buffer
//   Directed and randomized stimulus for password_entry_buffer, checked every
//   cycle against a digit-queue reference model. Define
//   PASSWORD_ENTRY_TIMEOUT_EN for both bench and design to exercise the
//   inactivity timeout.
module tb_password_entry_buffer;

  localparam int N   = 4;
  localparam int DW  = 4;
  localparam int MXD = 9;
  localparam int TO  = 16;
  localparam int EW  = N * DW;
  localparam int CW  = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] digit = '0;
  logic          confirm = 1'b0;
  logic          bksp = 1'b0;
  logic          clr = 1'b0;
  logic          submit = 1'b0;
  logic [EW-1:0] entry;
  logic [CW-1:0] count;
  logic [EW-1:0] code;
  logic          valid;
  logic          err;
  logic          tout;

  int checks = 0;
  int errors = 0;

  // Reference model: digits held oldest-first, plus held code and pulses.
  int            q[$];
  logic [EW-1:0] m_code = '0;
  bit            m_valid = 1'b0;
  bit            m_err = 1'b0;
  bit            m_to = 1'b0;
  int            idle_run = 0;

  password_entry_buffer #(
    .N_DIGITS      (N),
    .DIGIT_W       (DW),
    .MAX_DIGIT     (MXD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_digit    (digit),
    .i_confirm  (confirm),
    .i_backspace(bksp),
    .i_clear    (clr),
    .i_submit   (submit),
    .o_entry    (entry),
    .o_count    (count),
    .o_code     (code),
    .o_valid    (valid),
    .o_error    (err),
    .o_timeout  (tout)
  );

  always #5 clk = ~clk;

  // Value of the held digits as a number, newest digit least significant.
  function automatic logic [EW-1:0] model_entry();
    logic [EW-1:0] v = '0;
    foreach (q[i]) v = (v << DW) | EW'(q[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".entry"},   64'(entry), 64'(model_entry()));
    check({tag, ".count"},   64'(count), 64'(q.size()));
    check({tag, ".code"},    64'(code),  64'(m_code));
    check({tag, ".valid"},   64'(valid), 64'(m_valid));
    check({tag, ".error"},   64'(err),   64'(m_err));
    check({tag, ".timeout"}, 64'(tout),  64'(m_to));
  endtask

  // Apply one clock's worth of strobes to the reference model.
  task automatic model_step(input bit c, input int d, input bit b, input bit cl, input bit s);
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_to    = 1'b0;
    if (cl) begin
      q.delete();
    end else if (s) begin
      if (q.size() == N) begin
        m_code  = model_entry();
        m_valid = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      q.delete();
    end else if (b) begin
      if (q.size() == 0) m_err = 1'b1;
      else void'(q.pop_back());
    end else if (c) begin
      if (d > MXD || q.size() == N) m_err = 1'b1;
      else q.push_back(d);
    end
`ifdef PASSWORD_ENTRY_TIMEOUT_EN
    if (c || b || cl || s || q.size() == 0) begin
      idle_run = 0;
    end else begin
      idle_run++;
      if (idle_run == TO) begin
        q.delete();
        m_to     = 1'b1;
        idle_run = 0;
      end
    end
`endif
  endtask

  // Drive one cycle of strobes, clock it, then check all outputs.
  task automatic step(input string tag, input bit c, input int d, input bit b,
                      input bit cl, input bit s);
    digit   = DW'(d);
    confirm = c;
    bksp    = b;
    clr     = cl;
    submit  = s;
    @(posedge clk);
    model_step(c, d, b, cl, s);
    #1;
    check_all(tag);
    confirm = 1'b0;
    bksp    = 1'b0;
    clr     = 1'b0;
    submit  = 1'b0;
    $display("step %-10s c=%0d d=%0h b=%0d clr=%0d s=%0d -> entry=%h count=%0d code=%h v=%0d e=%0d t=%0d",
             tag, c, d, b, cl, s, entry, count, code, valid, err, tout);
  endtask

  task automatic conf(input string tag, input int d);
    step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    m_code   = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_to     = 1'b0;
    idle_run = 0;
  endtask

  initial begin
    // Reset state, visible without any clock edge.
    model_reset();
    #2;
    check_all("reset");
    #10;
    @(negedge clk);
    rst_n = 1'b1;

    // 1,2,3,4 then submit.
    conf("d1", 1);
    conf("d2", 2);
    conf("d3", 3);
    conf("d4", 4);
    check("full_entry", 64'(entry), 64'h1234);
    step("submit", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("code_1234", 64'(code), 64'h1234);
    idle("post_sub", 1);

    // Backspace mid-entry, fill, then a refused 5th digit.
    conf("d5", 5);
    conf("d6", 6);
    conf("d7", 7);
    step("bksp", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    conf("d8", 8);
    check("entry_568", 64'(entry), 64'h0568);
    conf("d0", 0);
    check("entry_5680", 64'(entry), 64'h5680);
    conf("d9_full", 9);
    check("full_refuse", 64'(entry), 64'h5680);
    step("bksp_full", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step("clear", 1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Out-of-range digits and errors on an empty buffer.
    conf("dA", 10);
    conf("dF", 15);
    step("bksp_empty", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step("clr_empty", 1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Partial submit keeps the previous code.
    conf("p1", 2);
    conf("p2", 7);
    step("sub_part", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("code_kept", 64'(code), 64'h1234);

    // Clear beats submit and confirm on a full buffer.
    for (int i = 0; i < N; i++) conf("fill", 9 - i);
    step("prio", 1'b1, 3, 1'b0, 1'b1, 1'b1);
    // Submit beats backspace.
    for (int i = 0; i < N; i++) conf("fill2", i + 4);
    step("sub_bksp", 1'b0, 0, 1'b1, 1'b0, 1'b1);
    check("code_4567", 64'(code), 64'h4567);

    // Timeout behaviour.
    conf("t1", 3);
    conf("t2", 7);
`ifdef PASSWORD_ENTRY_TIMEOUT_EN
    idle("t_idle", TO - 1);
    check("no_early_to", 64'(count), 64'd2);
    idle("t_fire", 1);
    check("to_pulse", 64'(tout), 64'd1);
    conf("u1", 3);
    conf("u2", 7);
    idle("u_idle", TO - 2);
    conf("u3", 5);
    check("to_preempt", 64'(count), 64'd3);
    idle("u_after", 1);
    step("u_clr", 1'b0, 0, 1'b0, 1'b1, 1'b0);
`else
    idle("t_idle", TO + 4);
    check("no_to", 64'(tout), 64'd0);
    check("no_to_cnt", 64'(count), 64'd2);
    step("t_clr", 1'b0, 0, 1'b0, 1'b1, 1'b0);
`endif

    // Asynchronous reset in the middle of a valid pulse.
    for (int i = 0; i < N; i++) conf("r_fill", i + 1);
    step("r_sub", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    conf("r_d", 6);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random mixed strobes, priority conflicts included.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 99) < 50), int'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 8));
    end
    // Mostly idle random traffic so partial entries can go stale.
    for (int i = 0; i < 600; i++) begin
      step("rnd_idle", ($urandom_range(0, 99) < 8), int'($urandom_range(0, 11)),
           ($urandom_range(0, 99) < 2), 1'b0, ($urandom_range(0, 99) < 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
